psum_ofifo: RTL
===============

// Module: psum_ofifo
// PURPOSE
//  Output FIFO directly downstream of the MAC array. Captures per-column partial sums on out_s,
//  using the array's per-column valid bits as column write strobes. Columns drain with different
//  skews, so each column is buffered independently. A full row is presented only when every
//  column holds data. Feeds the psum SRAM write path / accumulation stage.
// PARAMETERS
//  col      8   number of array columns (independent column queues)
//  psum_bw  16  partial-sum width per column
//  depth    64  entries per column queue; power of two, >=2
// PORTS
//  clk      in   1            rising-edge clock
//  reset    in   1            asynchronous, active-high reset
//  in       in   col*psum_bw  psums from array out_s; column i at [psum_bw*(i+1)-1:psum_bw*i]
//  wr       in   col          per-column write strobe (array valid); bit i writes column i
//  rd       in   1            pop one full row (all columns at once)
//  out      out  col*psum_bw  head row, same column packing as in
//  o_valid  out  1            every column non-empty; out is meaningful
//  o_full   out  1            at least one column queue full
//  o_ready  out  1            no column full (= ~o_full); upstream may keep draining the array
//  o_err    out  1            sticky overflow flag (only with PSUM_OFIFO_OVF_EN, else tied 0)
// BEHAVIOUR
//  - Per column: RAM depth x psum_bw, wr_ptr/rd_ptr of clog2(depth)+1 bits; the MSB disambiguates
//    full from empty. Full: ptr LSBs equal and MSBs differ. Empty: ptrs equal. Wrap: natural modulo.
//  - Reset (async): all ptrs 0; o_valid=0, o_full=0, o_ready=1, o_err=0, out=0. RAM contents are
//    not reset. Reset mid-operation discards all queued data immediately.
//  - Write: on posedge, if wr[i] and column i not full at the start of the cycle, store in-slice i
//    and increment wr_ptr[i]. wr[i] to a full column is dropped, with no pointer change, even if a
//    pop occurs in the same cycle (no pop-through).
//  - Read: on posedge, if rd && o_valid, increment every rd_ptr by one. rd while !o_valid is ignored.
//  - Simultaneous write and pop on a non-full column: both take effect; occupancy is unchanged.
//  - out: show-ahead, combinational from each column head; forced to all-zero when !o_valid.
//    Zero latency from rd to the next head.
//  - o_valid/o_full/o_ready: combinational from pointers only, never from rd/wr, so there is no
//    comb loop. Write-to-o_valid latency is 1 cycle (data written at edge N is visible after edge N).
//  - Arithmetic: no arithmetic on data; psums pass bit-exact. No sign handling.
//  - Column independence: wr is any bitmask. Columns may differ in occupancy by up to depth.
// CONFIGURATION
//  PSUM_OFIFO_OVF_EN defined: o_err is set on the first edge where wr[i] && column i full, for any
//    i. It clears only on reset.
//  PSUM_OFIFO_OVF_EN undefined: no overflow logic; o_err is tied to 1'b0. Drop behaviour is identical.
// TESTING
//  1 reset -> o_valid=0, o_full=0, o_ready=1, out=0, o_err=0; rd pulses ignored (ptrs stay 0).
//  2 wr=8'hFF with column i = 16'h0100+i for 3 cycles, then rd x3 -> three rows out in order,
//    o_valid then 0.
//  3 skewed fill: wr=8'h01, 8'h03, ... 8'hFF on successive cycles -> o_valid stays 0 until the
//    edge after 8'hFF. Col0 then holds 8 entries, col7 holds 1.
//  4 fill col3 with 64 writes -> o_full=1, o_ready=0. The 65th write (16'hDEAD) is dropped; with
//    PSUM_OFIFO_OVF_EN, o_err=1 and stays 1. Head order is preserved.
//  5 steady state, all cols half full: wr=8'hFF and rd=1 every cycle for 200 cycles -> occupancy
//    is constant, data in order, pointers wrap cleanly.
//  6 assert reset for 1 cycle while holding 10 rows -> o_valid=0 immediately; the next write row
//    is the first row read.

Source files
------------

// File: rtl/psum_ofifo.sv
// Per-column output FIFO behind the MAC array: independent column queues, row-wise show-ahead pop.
// Optional sticky overflow flag when PSUM_OFIFO_OVF_EN is defined; otherwise o_err is tied low.

module psum_ofifo_col #(
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [psum_bw-1:0] din,
    input  logic               push,
    input  logic               pop,
    output logic [psum_bw-1:0] head,
    output logic               empty,
    output logic               full
);
    localparam int AW = $clog2(depth);
    localparam logic [AW:0] ONE = 1;

    logic [AW:0]        wr_ptr, rd_ptr;
    logic [psum_bw-1:0] mem [depth];
    logic               do_wr;

    // Extra MSB on each pointer separates full (MSBs differ) from empty (equal).
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Full-at-start-of-cycle gate: a same-cycle pop never makes room for the write.
    assign do_wr = push & ~full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + ONE;
            if (pop)   rd_ptr <= rd_ptr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign head = mem[rd_ptr[AW-1:0]];
endmodule

module psum_ofifo #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col*psum_bw-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [col*psum_bw-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_err
);
    logic [col-1:0][psum_bw-1:0] head;
    logic [col-1:0]              empty;
    logic [col-1:0]              full;
    logic                        pop_row;

    // Flags depend only on pointer state, so rd/wr cannot form a comb loop through them.
    assign o_valid = ~|empty;
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign pop_row = rd & o_valid;
    assign out     = o_valid ? head : '0;

    for (genvar g = 0; g < col; g++) begin : g_col
        psum_ofifo_col #(
            .psum_bw(psum_bw),
            .depth  (depth)
        ) u_col (
            .clk  (clk),
            .reset(reset),
            .din  (in[g*psum_bw +: psum_bw]),
            .push (wr[g]),
            .pop  (pop_row),
            .head (head[g]),
            .empty(empty[g]),
            .full (full[g])
        );
    end

`ifdef PSUM_OFIFO_OVF_EN
    logic err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)             err_q <= 1'b0;
        else if (|(wr & full)) err_q <= 1'b1;
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif
endmodule
